hub75_frame_loader: RTL and testbench

- Upstream feeder for the HUB75 panel scan driver.
- Accepts a byte stream (R,G,B per pixel) from the host link receiver and assembles it into 24-bit pixels.
- Writes pixels into the write page of a two-page frame buffer; the scan driver reads from the other page.
- Swaps pages only on the driver's frame-boundary pulse, so the panel never shows a torn frame.

---
 rtl/hub75_pkg.sv | 22 ++
 rtl/hub75_pixel_packer.sv | 56 +++++
 rtl/hub75_frame_loader.sv | 128 ++++++++++++
 tb/tb_hub75_frame_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 frame loader: frame geometry defaults,
// colour field layout of a packed pixel and the loader state encoding.
package hub75_pkg;

   // Frame geometry: 32 columns x 16 rows x 2 banks
   localparam int PIXELS_DEF = 1024;
   localparam int ADDR_W_DEF = 10;

   // Packed pixel layout {B, G, R}, shared with the scan driver
   localparam int RED_LSB = 0;
   localparam int GRN_LSB = 8;
   localparam int BLU_LSB = 16;
   localparam int PIX_W   = 24;

   // Loader states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      PEND = 2'd2
   } state_t;

endpackage

// File: rtl/hub75_pixel_packer.sv
// Assembles the R,G,B byte stream into 24-bit pixels. A start-of-frame byte
// always becomes the red byte of a fresh pixel, dropping any partial pixel.
module hub75_pixel_packer
   import hub75_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_byte_vld,
   input  logic             i_sof,
   input  logic [7:0]       i_data,
   output logic [1:0]       o_byte_idx,
   output logic             o_pix_vld,
   output logic [PIX_W-1:0] o_pix
);

   logic [1:0] r_byte_idx;
   logic [7:0] r_red;
   logic [7:0] r_grn;

   // Byte position within the pixel: 0=R, 1=G, 2=B; never reaches 3
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_byte_idx <= 2'd0;
      end else if (i_byte_vld) begin
         if (i_sof) begin
            r_byte_idx <= 2'd1;
         end else if (r_byte_idx == 2'd2) begin
            r_byte_idx <= 2'd0;
         end else begin
            r_byte_idx <= r_byte_idx + 2'd1;
         end
      end
   end

   // Colour capture; these hold data only, so they carry no reset
   always_ff @(posedge i_clk) begin
      if (i_byte_vld) begin
         if (i_sof || r_byte_idx == 2'd0) begin
            r_red <= i_data;
         end else if (r_byte_idx == 2'd1) begin
            r_grn <= i_data;
         end
      end
   end

   // Pixel completes on the blue byte, which is used straight from the bus
   always_comb begin
      o_byte_idx             = r_byte_idx;
      o_pix_vld              = i_byte_vld & ~i_sof & (r_byte_idx == 2'd2);
      o_pix                  = '0;
      o_pix[RED_LSB +: 8]    = r_red;
      o_pix[GRN_LSB +: 8]    = r_grn;
      o_pix[BLU_LSB +: 8]    = i_data;
   end

endmodule

// File: rtl/hub75_frame_loader.sv
// HUB75 frame loader: writes an incoming pixel stream into the back page of a
// two-page frame buffer and swaps pages only on the scan driver's frame-end
// pulse, so the panel never displays a partially written frame.
module hub75_frame_loader
   import hub75_pkg::*;
#(
   parameter int PIXELS = PIXELS_DEF,
   parameter int ADDR_W = ADDR_W_DEF
)
(
   input  logic              CLK_I,
   input  logic              RST_I,
   input  logic [7:0]        DATA_I,
   input  logic              VALID_I,
   input  logic              SOF_I,
   output logic              READY_O,
   input  logic              VSYNC_I,
   output logic              WE_O,
   output logic [ADDR_W:0]   WADDR_O,
   output logic [PIX_W-1:0]  WDATA_O,
   output logic              PAGE_O,
   output logic              FRAME_DONE_O,
   output logic              ERR_O
);

   localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(PIXELS - 1);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_pix_cnt;
   logic                r_page;
   logic                r_we;
   logic [ADDR_W:0]     r_waddr;
   logic [PIX_W-1:0]    r_wdata;
   logic                r_frame_done;
   logic                r_err;

   logic                w_ready;
   logic                w_accept;
   logic                w_sof;
   logic                w_byte_vld;
   logic [1:0]          w_byte_idx;
   logic                w_pix_vld;
   logic [PIX_W-1:0]    w_pix;

   // Handshake decode; in IDLE only a start-of-frame byte reaches the packer
   always_comb begin
      w_ready    = (r_state != PEND);
      w_accept   = VALID_I & w_ready;
      w_sof      = w_accept & SOF_I;
      w_byte_vld = w_accept & ((r_state == RECV) | SOF_I);
   end

   hub75_pixel_packer u_packer (
      .i_clk      (CLK_I),
      .i_rst      (RST_I),
      .i_byte_vld (w_byte_vld),
      .i_sof      (w_sof),
      .i_data     (DATA_I),
      .o_byte_idx (w_byte_idx),
      .o_pix_vld  (w_pix_vld),
      .o_pix      (w_pix)
   );

   // Frame FSM: pixel addressing, registered write port, page swap and error
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         r_state      <= IDLE;
         r_pix_cnt    <= '0;
         r_page       <= 1'b0;
         r_we         <= 1'b0;
         r_waddr      <= '0;
         r_wdata      <= '0;
         r_frame_done <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_we         <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_sof) begin
                  r_pix_cnt <= '0;
                  r_state   <= RECV;
               end
            end
            RECV: begin
               if (w_sof) begin
                  // Restart on the same page; only a mid-frame SOF is an error
                  if (w_byte_idx != 2'd0 || r_pix_cnt != '0) begin
                     r_err <= 1'b1;
                  end
                  r_pix_cnt <= '0;
               end else if (w_pix_vld) begin
                  r_we    <= 1'b1;
                  r_waddr <= {~r_page, r_pix_cnt};
                  r_wdata <= w_pix;
                  if (r_pix_cnt == PIX_LAST) begin
                     r_pix_cnt <= '0;
                     r_state   <= PEND;
                  end else begin
                     r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
                  end
               end
            end
            PEND: begin
               // The cycle carrying the final write still belongs to the frame,
               // so a frame-end pulse there is too early to swap on
               if (VSYNC_I && !r_we) begin
                  r_page       <= ~r_page;
                  r_frame_done <= 1'b1;
                  r_state      <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign READY_O      = w_ready;
   assign WE_O         = r_we;
   assign WADDR_O      = r_waddr;
   assign WDATA_O      = r_wdata;
   assign PAGE_O       = r_page;
   assign FRAME_DONE_O = r_frame_done;
   assign ERR_O        = r_err;

endmodule

// File: tb/tb_hub75_frame_loader.sv
// Scoreboard bench for hub75_frame_loader: stimulus pushes the expected write
// (address, pixel, cycle) per pixel; a monitor pops and compares each WE_O.
module tb_hub75_frame_loader;

   logic        CLK_I = 1'b0;
   logic        RST_I = 1'b1;
   logic [7:0]  DATA_I = 8'h00;
   logic        VALID_I = 1'b0;
   logic        SOF_I = 1'b0;
   logic        READY_O;
   logic        VSYNC_I = 1'b0;
   logic        WE_O;
   logic [10:0] WADDR_O;
   logic [23:0] WDATA_O;
   logic        PAGE_O;
   logic        FRAME_DONE_O;
   logic        ERR_O;

   typedef struct {
      logic [10:0] addr;
      logic [23:0] data;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   nwr = 0;
   int   fd_cnt = 0;

   hub75_frame_loader #(.PIXELS(1024), .ADDR_W(10)) dut (
      .CLK_I        (CLK_I),
      .RST_I        (RST_I),
      .DATA_I       (DATA_I),
      .VALID_I      (VALID_I),
      .SOF_I        (SOF_I),
      .READY_O      (READY_O),
      .VSYNC_I      (VSYNC_I),
      .WE_O         (WE_O),
      .WADDR_O      (WADDR_O),
      .WDATA_O      (WDATA_O),
      .PAGE_O       (PAGE_O),
      .FRAME_DONE_O (FRAME_DONE_O),
      .ERR_O        (ERR_O)
   );

   always #5 CLK_I = ~CLK_I;

   always @(posedge CLK_I) cyc <= cyc + 1;

   // Write monitor: every WE_O must match the oldest expected write
   always @(negedge CLK_I) begin
      if (FRAME_DONE_O === 1'b1) fd_cnt++;
      if (WE_O === 1'b1) begin
         nwr++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write cyc=%0d addr=%h data=%h", cyc, WADDR_O, WDATA_O);
         end else begin
            mon_e = sb.pop_front();
            if (WADDR_O !== mon_e.addr || WDATA_O !== mon_e.data || cyc != mon_e.cyc) begin
               errors++;
               $display("FAIL write got addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                        WADDR_O, WDATA_O, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %h required %h", nm, act, req);
      end
   endtask

   task automatic idle();
      @(posedge CLK_I);
      #1;
   endtask

   // One byte with VALID_I for a single cycle; returns the cycle index of the
   // edge that accepts it (the registered write shows up in that same index)
   task automatic send_byte(input logic [7:0] d, input logic s, output int acc_cyc);
      DATA_I  = d;
      SOF_I   = s;
      VALID_I = 1'b1;
      chk("ready_on_send", {31'd0, READY_O}, 32'd1);
      @(posedge CLK_I);
      #1;
      acc_cyc = cyc;
      VALID_I = 1'b0;
      SOF_I   = 1'b0;
      DATA_I  = 8'h00;
   endtask

   task automatic send_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           input logic s, input logic [10:0] addr, input int gap);
      int c;
      send_byte(r, s, c);
      repeat (gap) idle();
      send_byte(g, 1'b0, c);
      repeat (gap) idle();
      send_byte(b, 1'b0, c);
      sb.push_back('{addr, {b, g, r}, c});
   endtask

   task automatic pulse_vsync();
      VSYNC_I = 1'b1;
      @(posedge CLK_I);
      #1;
      VSYNC_I = 1'b0;
   endtask

   initial begin
      int c;
      int base;
      logic [9:0] iv;

      // Reset state
      repeat (3) @(posedge CLK_I);
      #1;
      chk("rst_ready", {31'd0, READY_O}, 32'd1);
      chk("rst_we", {31'd0, WE_O}, 32'd0);
      chk("rst_waddr", {21'd0, WADDR_O}, 32'd0);
      chk("rst_wdata", {8'd0, WDATA_O}, 32'd0);
      chk("rst_page", {31'd0, PAGE_O}, 32'd0);
      chk("rst_fd", {31'd0, FRAME_DONE_O}, 32'd0);
      chk("rst_err", {31'd0, ERR_O}, 32'd0);
      RST_I = 1'b0;
      idle();
      chk("post_rst_ready", {31'd0, READY_O}, 32'd1);

      // Bytes without SOF in IDLE, VALID_I every other cycle: no writes
      for (int i = 0; i < 6; i++) begin
         send_byte(8'h40 + 8'(i), 1'b0, c);
         idle();
      end

      // Frame A into page 1 (display page 0), gaps on the first pixels
      for (int i = 0; i < 1024; i++) begin
         send_pix(8'h11, 8'h22, 8'h33, (i == 0), 11'h400 + 11'(i), (i < 4) ? 1 : 0);
      end
      idle();
      chk("pend_ready", {31'd0, READY_O}, 32'd0);
      // Attempted SOF bytes while pending must be refused
      VALID_I = 1'b1;
      SOF_I   = 1'b1;
      DATA_I  = 8'h55;
      repeat (3) idle();
      VALID_I = 1'b0;
      SOF_I   = 1'b0;
      repeat (16) idle();
      chk("pend_page", {31'd0, PAGE_O}, 32'd0);
      chk("pend_ready2", {31'd0, READY_O}, 32'd0);
      chk("pend_err", {31'd0, ERR_O}, 32'd0);

      // Frame-end pulse swaps the page with a single FRAME_DONE_O
      pulse_vsync();
      chk("swap1_fd", {31'd0, FRAME_DONE_O}, 32'd1);
      chk("swap1_page", {31'd0, PAGE_O}, 32'd1);
      idle();
      chk("swap1_fd_low", {31'd0, FRAME_DONE_O}, 32'd0);
      chk("swap1_ready", {31'd0, READY_O}, 32'd1);

      // Frame B into page 0 with varied data; VSYNC_I lands on the final write
      for (int i = 0; i < 1024; i++) begin
         iv = 10'(i);
         send_pix(iv[7:0], ~iv[7:0], iv[9:2], (i == 0), {1'b0, iv}, 0);
      end
      chk("final_we", {31'd0, WE_O}, 32'd1);
      pulse_vsync();
      chk("coinc_page", {31'd0, PAGE_O}, 32'd1);
      chk("coinc_fd", {31'd0, FRAME_DONE_O}, 32'd0);
      repeat (5) idle();
      chk("coinc_page2", {31'd0, PAGE_O}, 32'd1);
      chk("coinc_ready", {31'd0, READY_O}, 32'd0);
      pulse_vsync();
      chk("swap2_fd", {31'd0, FRAME_DONE_O}, 32'd1);
      chk("swap2_page", {31'd0, PAGE_O}, 32'd0);

      // Frame C: 5 pixels + 1 byte, then SOF restarts on the same page
      base = nwr;
      for (int i = 0; i < 5; i++) begin
         send_pix(8'hA0 + 8'(i), 8'hB0 + 8'(i), 8'hC0 + 8'(i), (i == 0), 11'h400 + 11'(i), 0);
      end
      send_byte(8'h77, 1'b0, c);
      chk("pre_restart_err", {31'd0, ERR_O}, 32'd0);
      send_pix(8'hC1, 8'hC2, 8'hC3, 1'b1, 11'h400, 0);
      chk("restart_err", {31'd0, ERR_O}, 32'd1);
      chk("writes_before_restart", nwr - base, 32'd5);
      for (int i = 1; i < 1024; i++) begin
         iv = 10'(i);
         send_pix(iv[9:2], iv[7:0] ^ 8'h5A, iv[7:0], 1'b0, {1'b1, iv}, 0);
      end
      idle();
      chk("err_sticky", {31'd0, ERR_O}, 32'd1);
      pulse_vsync();
      chk("swap3_page", {31'd0, PAGE_O}, 32'd1);
      chk("swap3_err", {31'd0, ERR_O}, 32'd1);

      // Frame D: reset at pixel 300 while displaying page 1
      for (int i = 0; i < 300; i++) begin
         iv = 10'(i);
         send_pix(8'h01, iv[7:0], 8'h02, (i == 0), {1'b0, iv}, 0);
      end
      send_byte(8'hEE, 1'b0, c);
      RST_I = 1'b1;
      idle();
      RST_I = 1'b0;
      chk("midrst_page", {31'd0, PAGE_O}, 32'd0);
      chk("midrst_ready", {31'd0, READY_O}, 32'd1);
      chk("midrst_err", {31'd0, ERR_O}, 32'd0);
      chk("midrst_we", {31'd0, WE_O}, 32'd0);

      // Frame E starts again on the back page of page 0
      for (int i = 0; i < 3; i++) begin
         send_pix(8'h90, 8'h91, 8'h92 + 8'(i), (i == 0), 11'h400 + 11'(i), 0);
      end
      repeat (3) idle();
      chk("sb_drained", sb.size(), 32'd0);
      chk("frame_done_count", fd_cnt, 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
